// File: rtl/sram_arbiter.sv
// Shares one SRAM-like memory port between fetch and load/store ports, one transaction at a time; grant->mem_req 1 cycle, ok pulses follow mem handshakes combinationally.
// Requesters hold req until addr_ok; `SRAM_ARB_ROUND_ROBIN_EN swaps fixed data-first priority for round-robin.
module sram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  input  logic          inst_cancel,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [3:0]    data_wstrb,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [3:0]    mem_wstrb,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_addr_ok,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_data_ok
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_I_ADDR = 3'd1,
    S_I_DATA = 3'd2,
    S_D_ADDR = 3'd3,
    S_D_DATA = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_wr;
  logic [3:0]    r_wstrb;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_cancel;
  logic          w_grant_d;
  logic          w_grant_i;
  logic          w_inst_own;
  logic          w_cancel;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // r_prio_d=1 means the data port wins a tie; flips to the other side at every grant.
  logic r_prio_d;
  always_ff @(posedge clk) begin
    if (rst)
      r_prio_d <= 1'b1;
    else if (w_grant_d || w_grant_i)
      r_prio_d <= w_grant_i;
  end
  assign w_grant_d = (r_state == S_IDLE) && data_req && (!inst_req || r_prio_d);
`else
  assign w_grant_d = (r_state == S_IDLE) && data_req;
`endif
  assign w_grant_i  = (r_state == S_IDLE) && inst_req && !w_grant_d;
  assign w_inst_own = (r_state == S_I_ADDR) || (r_state == S_I_DATA);
  // A cancel arriving in the same cycle as the handshake already hides that pulse.
  assign w_cancel   = r_cancel || inst_cancel;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d)
          w_next = S_D_ADDR;
        else if (w_grant_i)
          w_next = S_I_ADDR;
      end
      S_I_ADDR: if (mem_addr_ok) w_next = S_I_DATA;
      S_I_DATA: if (mem_data_ok) w_next = S_IDLE;
      S_D_ADDR: if (mem_addr_ok) w_next = S_D_DATA;
      S_D_DATA: if (mem_data_ok) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr     <= 1'b0;
      r_wstrb  <= 4'h0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cancel <= 1'b0;
    end else begin
      if (w_grant_d) begin
        r_wr    <= data_wr;
        r_wstrb <= data_wstrb;
        r_addr  <= data_addr;
        r_wdata <= data_wdata;
      end else if (w_grant_i) begin
        r_wr    <= 1'b0;
        r_wstrb <= 4'h0;
        r_addr  <= inst_addr;
        r_wdata <= '0;
      end
      if (w_next == S_IDLE)
        r_cancel <= 1'b0;
      else if (w_inst_own && inst_cancel)
        r_cancel <= 1'b1;
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (!rst) begin
      case (r_state)
        S_I_ADDR: begin
          mem_req      = 1'b1;
          inst_addr_ok = mem_addr_ok && !w_cancel;
        end
        S_I_DATA: inst_data_ok = mem_data_ok && !w_cancel;
        S_D_ADDR: begin
          mem_req      = 1'b1;
          data_addr_ok = mem_addr_ok;
        end
        S_D_DATA: data_data_ok = mem_data_ok;
        default: ;
      endcase
    end
    mem_wr     = mem_req && r_wr;
    mem_wstrb  = mem_req ? r_wstrb : 4'h0;
    mem_addr   = mem_req ? r_addr  : '0;
    mem_wdata  = mem_req ? r_wdata : '0;
    inst_rdata = inst_data_ok ? mem_rdata : '0;
    data_rdata = data_data_ok ? mem_rdata : '0;
  end

endmodule
